pueo_command_encoder_mux: RTL and testbench



---
 rtl/pueo_command_pkg.sv | 30 +++
 rtl/pueo_rr_arbiter.sv | 35 +++
 rtl/pueo_command_encoder_mux.sv | 131 +++++++++++++
 tb/tb_pueo_command_encoder_mux.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pueo_command_pkg.sv
// Shared constants and payload types for the PUEO per-frame command word.
// Word layout: {type[3:0], data[11:0], trig[15:0]}.
package pueo_command_pkg;

  localparam int unsigned CMD_W  = 32;
  localparam int unsigned TYPE_W = 4;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned TRIG_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DEST_W = 4;

  localparam logic [TYPE_W-1:0] CMDTYPE_BIT     = 4'b0000;
  localparam logic [TYPE_W-1:0] CMDTYPE_CMD     = 4'b0001;
  localparam logic [TYPE_W-1:0] CMDTYPE_CMDLAST = 4'b0101;
  localparam logic [TYPE_W-1:0] CMDTYPE_NOP     = 4'b1010;

  typedef struct packed {
    logic [TYPE_W-1:0] ctype;
    logic [DATA_W-1:0] data;
    logic [TRIG_W-1:0] trig;
  } cmd_word_t;

  localparam cmd_word_t CMD_NOP_WORD = '{ctype: CMDTYPE_NOP, data: '0, trig: '0};

  // Command-processor byte type: tlast selects the "last byte" flavour.
  function automatic logic [TYPE_W-1:0] cmd_type(input logic last);
    return last ? CMDTYPE_CMDLAST : CMDTYPE_CMD;
  endfunction

endpackage

// File: rtl/pueo_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after the
// pointer (wrapping) wins.
// Ports: req_i (requests), ptr_i (last granted index), gnt_c_o (one-hot
// grant), idx_c_o (granted index), any_c_o (any request).
module pueo_rr_arbiter
  import pueo_command_pkg::*;
#(
  parameter int unsigned NSRC = 2,
  localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NSRC-1:0] gnt_c_o,
  output logic [IDXW-1:0] idx_c_o,
  output logic            any_c_o
);

  // Scan ptr+1 .. ptr+NSRC; the pointer itself is visited last.
  always_comb begin
    int unsigned cand;
    gnt_c_o = '0;
    idx_c_o = '0;
    any_c_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= NSRC; off++) begin
      cand = (32'(ptr_i) + off) % NSRC;
      if (!any_c_o && req_i[IDXW'(cand)]) begin
        any_c_o                = 1'b1;
        idx_c_o                = IDXW'(cand);
        gnt_c_o[IDXW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pueo_command_encoder_mux.sv
// Builds the 32-bit per-frame command word sent to the SURFs, arbitrating
// bit commands (highest priority), NSRC command-processor byte streams
// (round-robin) and the trigger stream (independent field).
// Ports: sysclk_i/rst_i (sync active-high), sysclk_phase_i (frame marker),
// command_o, bitcommand_i/bitcommand_ack, cmdproc_t* (per-source AXI-S
// bytes, one-hot tready pulse), trig_t* (trigger stream, tready pulse).
// Build option: PUEO_CMDENC_BITCMD_STICKY_EN latches bit-command pulses
// between captures so single-cycle requests are never lost.
module pueo_command_encoder_mux
  import pueo_command_pkg::*;
#(
  parameter int unsigned NPHASE        = 8,
  parameter int unsigned CAPTURE_PHASE = 5,
  parameter int unsigned NSRC          = 2
) (
  input  logic                   sysclk_i,
  input  logic                   rst_i,
  input  logic                   sysclk_phase_i,
  output logic [CMD_W-1:0]       command_o,
  input  logic [DATA_W-1:0]      bitcommand_i,
  output logic                   bitcommand_ack,
  input  logic [BYTE_W*NSRC-1:0] cmdproc_tdata,
  input  logic [DEST_W*NSRC-1:0] cmdproc_tuser,
  input  logic [NSRC-1:0]        cmdproc_tlast,
  input  logic [NSRC-1:0]        cmdproc_tvalid,
  output logic [NSRC-1:0]        cmdproc_tready,
  input  logic [TRIG_W-2:0]      trig_tdata,
  input  logic                   trig_tvalid,
  output logic                   trig_tready
);

  localparam int unsigned PHW  = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PHW-1:0]    phase_q, phase_d;
  logic              capture_q, capture_d;
  cmd_word_t         cmd_q, cmd_d;
  logic              bitack_q, bitack_d;
  logic [NSRC-1:0]   tready_q, tready_d;
  logic              trigack_q, trigack_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;

  logic [DATA_W-1:0] bitdata_c;
  logic [NSRC-1:0]   gnt_c;
  logic [IDXW-1:0]   gnt_idx_c;
  logic              gnt_any_c;
  int unsigned       sel_c;

  pueo_rr_arbiter #(.NSRC(NSRC)) u_arb (
    .req_i   (cmdproc_tvalid),
    .ptr_i   (ptr_q),
    .gnt_c_o (gnt_c),
    .idx_c_o (gnt_idx_c),
    .any_c_o (gnt_any_c)
  );

`ifdef PUEO_CMDENC_BITCMD_STICKY_EN
  logic [DATA_W-1:0] pending_q, pending_d;

  // Accumulate bit requests; cleared when they go out at capture.
  always_comb begin
    bitdata_c = pending_q | bitcommand_i;
    pending_d = bitdata_c;
    if (capture_q) pending_d = '0;
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end
`else
  assign bitdata_c = bitcommand_i;
`endif

  // Next-state: phase tracking, then priority encode on the capture cycle.
  always_comb begin
    phase_d   = sysclk_phase_i ? PHW'(1) : phase_q + PHW'(1);
    capture_d = (phase_q == PHW'(CAPTURE_PHASE));
    cmd_d     = cmd_q;
    bitack_d  = 1'b0;
    tready_d  = '0;
    trigack_d = 1'b0;
    ptr_d     = ptr_q;
    sel_c     = 32'(gnt_idx_c);
    if (capture_q) begin
      cmd_d.trig = {trig_tvalid, trig_tdata};
      trigack_d  = trig_tvalid;
      if (|bitdata_c) begin
        cmd_d.ctype = CMDTYPE_BIT;
        cmd_d.data  = bitdata_c;
        bitack_d    = 1'b1;
      end else if (gnt_any_c) begin
        cmd_d.ctype = cmd_type(cmdproc_tlast[gnt_idx_c]);
        cmd_d.data  = {cmdproc_tuser[sel_c*DEST_W +: DEST_W],
                       cmdproc_tdata[sel_c*BYTE_W +: BYTE_W]};
        tready_d    = gnt_c;
        ptr_d       = gnt_idx_c;
      end else begin
        cmd_d.ctype = CMDTYPE_NOP;
        cmd_d.data  = '0;
      end
    end
  end

  // State register; reset also drops any pulse that would have issued.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      phase_q   <= '0;
      capture_q <= 1'b0;
      cmd_q     <= CMD_NOP_WORD;
      bitack_q  <= 1'b0;
      tready_q  <= '0;
      trigack_q <= 1'b0;
      ptr_q     <= IDXW'(NSRC - 1);
    end else begin
      phase_q   <= phase_d;
      capture_q <= capture_d;
      cmd_q     <= cmd_d;
      bitack_q  <= bitack_d;
      tready_q  <= tready_d;
      trigack_q <= trigack_d;
      ptr_q     <= ptr_d;
    end
  end

  assign command_o      = cmd_q;
  assign bitcommand_ack = bitack_q;
  assign cmdproc_tready = tready_q;
  assign trig_tready    = trigack_q;

endmodule

// File: tb/tb_pueo_command_encoder_mux.sv
// Directed bench for pueo_command_encoder_mux (NPHASE=8, CAPTURE_PHASE=5,
// NSRC=2). Frame marker at edge E0 -> capture cycle after E5 -> outputs
// and pulses visible between E6 and E7.
module tb_pueo_command_encoder_mux;

  localparam int unsigned NSRC = 2;

  logic             sysclk_i;
  logic             rst_i;
  logic             sysclk_phase_i;
  logic [31:0]      command_o;
  logic [11:0]      bitcommand_i;
  logic             bitcommand_ack;
  logic [8*NSRC-1:0] cmdproc_tdata;
  logic [4*NSRC-1:0] cmdproc_tuser;
  logic [NSRC-1:0]  cmdproc_tlast;
  logic [NSRC-1:0]  cmdproc_tvalid;
  logic [NSRC-1:0]  cmdproc_tready;
  logic [14:0]      trig_tdata;
  logic             trig_tvalid;
  logic             trig_tready;

  pueo_command_encoder_mux #(.NPHASE(8), .CAPTURE_PHASE(5), .NSRC(NSRC)) dut (
    .sysclk_i       (sysclk_i),
    .rst_i          (rst_i),
    .sysclk_phase_i (sysclk_phase_i),
    .command_o      (command_o),
    .bitcommand_i   (bitcommand_i),
    .bitcommand_ack (bitcommand_ack),
    .cmdproc_tdata  (cmdproc_tdata),
    .cmdproc_tuser  (cmdproc_tuser),
    .cmdproc_tlast  (cmdproc_tlast),
    .cmdproc_tvalid (cmdproc_tvalid),
    .cmdproc_tready (cmdproc_tready),
    .trig_tdata     (trig_tdata),
    .trig_tvalid    (trig_tvalid),
    .trig_tready    (trig_tready)
  );

  initial sysclk_i = 1'b0;
  always #5 sysclk_i = ~sysclk_i;

  int n_vec;
  int n_miscmp;

  // Per-frame observations
  logic [31:0]     word6, word7;
  logic            back6, tack6;
  logic [NSRC-1:0] rdy_or;
  int              n_back, n_tack, n_rdy, n_multi;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at #1 after an edge; ends at #1 after E7.
  task automatic run_frame(input logic [11:0] bc_pulse, input bit rst_cap);
    sysclk_phase_i = 1'b1;
    @(posedge sysclk_i); #1;
    sysclk_phase_i = 1'b0;
    if (bc_pulse != 12'h000) bitcommand_i = bc_pulse;
    n_back = 0; n_tack = 0; n_rdy = 0; rdy_or = '0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge sysclk_i); #1;
      if (k == 1 && bc_pulse != 12'h000) bitcommand_i = 12'h000;
      if (bitcommand_ack) n_back++;
      if (trig_tready) n_tack++;
      if (|cmdproc_tready) n_rdy++;
      if ($countones(cmdproc_tready) > 1) n_multi++;
      rdy_or = rdy_or | cmdproc_tready;
      if (k == 6) begin
        word6 = command_o;
        back6 = bitcommand_ack;
        tack6 = trig_tready;
      end
      if (k == 7) word7 = command_o;
      if (rst_cap && k == 5) rst_i = 1'b1;
      if (rst_cap && k == 6) rst_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge sysclk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Alternation table: valid, tlast, expected word, expected ready
  logic [NSRC-1:0] alt_valid [4] = '{2'b11, 2'b11, 2'b11, 2'b10};
  logic [NSRC-1:0] alt_last  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [31:0]     alt_word  [4] = '{32'h1211_0000, 32'h1322_0000, 32'h5211_0000, 32'h5322_0000};
  logic [NSRC-1:0] alt_rdy   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    n_vec = 0; n_miscmp = 0; n_multi = 0;
    rst_i = 1'b1; sysclk_phase_i = 1'b0; bitcommand_i = '0;
    cmdproc_tdata = '0; cmdproc_tuser = '0; cmdproc_tlast = '0; cmdproc_tvalid = '0;
    trig_tdata = '0; trig_tvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge sysclk_i);
    #1;
    check_eq("rst_cmd", command_o, 32'hA000_0000);
    check_eq("rst_back", 32'(bitcommand_ack), 32'd0);
    check_eq("rst_rdy", 32'(cmdproc_tready), 32'd0);
    check_eq("rst_tack", 32'(trig_tready), 32'd0);
    rst_i = 1'b0;

    // Idle frames: NOP, no pulses
    run_frame(12'h000, 1'b0);
    check_eq("idle_word", word6, 32'hA000_0000);
    check_eq("idle_back", 32'(n_back), 32'd0);
    check_eq("idle_rdy", 32'(n_rdy), 32'd0);
    check_eq("idle_tack", 32'(n_tack), 32'd0);

    // Bit command beats a waiting cmdproc byte
    bitcommand_i = 12'h005;
    cmdproc_tvalid = 2'b01; cmdproc_tdata = 16'h003C; cmdproc_tuser = 8'h02; cmdproc_tlast = 2'b00;
    run_frame(12'h000, 1'b0);
    check_eq("bit_word", word6, 32'h0005_0000);
    check_eq("bit_back", 32'(n_back), 32'd1);
    check_eq("bit_rdy", 32'(n_rdy), 32'd0);
    check_eq("bit_hold", word7, 32'h0005_0000);
    bitcommand_i = 12'h000;
    run_frame(12'h000, 1'b0);
    check_eq("cmd0_word", word6, 32'h123C_0000);
    check_eq("cmd0_rdy", 32'(rdy_or), 32'h1);
    check_eq("cmd0_rdycnt", 32'(n_rdy), 32'd1);
    check_eq("cmd0_back", 32'(n_back), 32'd0);
    cmdproc_tvalid = '0;

    // Round-robin alternation from a fresh pointer
    do_reset();
    cmdproc_tdata = 16'h2211; cmdproc_tuser = 8'h32;
    for (int i = 0; i < 4; i++) begin
      cmdproc_tvalid = alt_valid[i];
      cmdproc_tlast  = alt_last[i];
      run_frame(12'h000, 1'b0);
      check_eq($sformatf("rr%0d_word", i), word6, alt_word[i]);
      check_eq($sformatf("rr%0d_rdy", i), 32'(rdy_or), 32'(alt_rdy[i]));
    end
    cmdproc_tvalid = '0; cmdproc_tlast = '0;

    // Trigger rides alongside a bit command
    trig_tvalid = 1'b1; trig_tdata = 15'h1234; bitcommand_i = 12'h0AB;
    run_frame(12'h000, 1'b0);
    check_eq("trig_word", word6, 32'h00AB_9234);
    check_eq("trig_both", 32'({back6, tack6}), 32'h3);
    check_eq("trig_tackcnt", 32'(n_tack), 32'd1);
    check_eq("trig_backcnt", 32'(n_back), 32'd1);
    trig_tvalid = 1'b0; trig_tdata = '0; bitcommand_i = 12'h000;
    run_frame(12'h000, 1'b0);
    check_eq("trig_clear", word6, 32'hA000_0000);

    // Reset lands on the capture cycle: byte not consumed, retried later
    cmdproc_tvalid = 2'b01; cmdproc_tdata = 16'h005A; cmdproc_tuser = 8'h04; cmdproc_tlast = 2'b01;
    run_frame(12'h000, 1'b1);
    check_eq("rstcap_word", word6, 32'hA000_0000);
    check_eq("rstcap_rdy", 32'(n_rdy), 32'd0);
    run_frame(12'h000, 1'b0);
    check_eq("retry_word", word6, 32'h545A_0000);
    check_eq("retry_rdy", 32'(rdy_or), 32'h1);
    cmdproc_tvalid = '0; cmdproc_tlast = '0;

    // Single-cycle bit command at phase 1
    run_frame(12'h800, 1'b0);
`ifdef PUEO_CMDENC_BITCMD_STICKY_EN
    check_eq("pulse_word", word6, 32'h0800_0000);
    check_eq("pulse_back", 32'(n_back), 32'd1);
`else
    check_eq("pulse_word", word6, 32'hA000_0000);
    check_eq("pulse_back", 32'(n_back), 32'd0);
`endif

    check_eq("onehot_rdy", 32'(n_multi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
